ucsbece154a_memif: RTL and testbench

- Memory-request initiator sitting between the multicycle controller/datapath and ucsbece154a_mem.
- Accepts one word fetch/load/store request per handshake and drives the memory's address, write-enable and write-data pins.
- Captures read data into a response register and reports address faults instead of letting invalid stores or undriven reads reach the datapath.
- Models configurable memory wait states so the controller tolerates slower memories.

---
 rtl/ucsbece154a_memif_pkg.sv | 19 +
 rtl/ucsbece154a_memif_if.sv | 24 ++
 rtl/ucsbece154a_addrchk.sv | 25 ++
 rtl/ucsbece154a_memif.sv | 124 ++++++++++++
 tb/tb_ucsbece154a_memif.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ucsbece154a_memif_pkg.sv
// Shared address map, FSM state encoding and helpers for the memory-request initiator.
package ucsbece154a_memif_pkg;

  localparam logic [31:0] TEXT_START_DEF = 32'h0040_0000;
  localparam logic [31:0] DATA_START_DEF = 32'h1000_0000;
  localparam int          TEXT_SIZE_DEF  = 64;
  localparam int          DATA_SIZE_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } memifState_e;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ucsbece154a_memif_if.sv
// Request/response handshake between the multicycle controller (master) and the memory initiator (slave).
interface ucsbece154a_memif_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/ucsbece154a_addrchk.sv
// Combinational address-map check: flags addresses outside text/data and stores into text.
module ucsbece154a_addrchk
  import ucsbece154a_memif_pkg::*;
#(
  parameter logic [31:0] TEXT_START = TEXT_START_DEF,
  parameter int          TEXT_SIZE  = TEXT_SIZE_DEF,
  parameter logic [31:0] DATA_START = DATA_START_DEF,
  parameter int          DATA_SIZE  = DATA_SIZE_DEF
) (
  input  logic [31:0] i_addr,
  input  logic        i_we,
  output logic        o_fault
);

  localparam logic [31:0] TEXT_END = TEXT_START + 32'(4 * TEXT_SIZE);
  localparam logic [31:0] DATA_END = DATA_START + 32'(4 * DATA_SIZE);

  logic w_inText;
  logic w_inData;

  assign w_inText = (i_addr >= TEXT_START) && (i_addr < TEXT_END);
  assign w_inData = (i_addr >= DATA_START) && (i_addr < DATA_END);
  assign o_fault  = !(w_inText || w_inData) || (i_we && w_inText);

endmodule

// File: rtl/ucsbece154a_memif.sv
// Memory-request initiator with configurable wait states and fault reporting.
// Build option: UCSBECE154A_MEMIF_ALIGN_CHECK_EN makes misaligned addresses fault instead of being word-aligned.
module ucsbece154a_memif
  import ucsbece154a_memif_pkg::*;
#(
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] TEXT_START  = TEXT_START_DEF,
  parameter int          TEXT_SIZE   = TEXT_SIZE_DEF,
  parameter logic [31:0] DATA_START  = DATA_START_DEF,
  parameter int          DATA_SIZE   = DATA_SIZE_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  ucsbece154a_memif_if.slave        bus,
  output logic                      mem_we_o,
  output logic [31:0]               mem_a_o,
  output logic [31:0]               mem_wd_o,
  input  logic [31:0]               mem_rd_i
);

  memifState_e r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_fault;
  logic        r_reqReady;
  logic        r_rspValid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_memWe;
  logic [31:0] r_memA;
  logic [31:0] r_memWd;

  logic [31:0] w_addr;
  logic        w_regionFault;
  logic        w_misFault;
  logic        w_fault;

`ifdef UCSBECE154A_MEMIF_ALIGN_CHECK_EN
  assign w_addr     = bus.req_addr_i;
  assign w_misFault = |bus.req_addr_i[1:0];
`else
  assign w_addr     = wordAlign(bus.req_addr_i);
  assign w_misFault = 1'b0;
`endif

  ucsbece154a_addrchk #(
    .TEXT_START (TEXT_START),
    .TEXT_SIZE  (TEXT_SIZE),
    .DATA_START (DATA_START),
    .DATA_SIZE  (DATA_SIZE)
  ) u_addrchk (
    .i_addr  (w_addr),
    .i_we    (bus.req_we_i),
    .o_fault (w_regionFault)
  );

  assign w_fault = w_regionFault | w_misFault;

  // mem_we is registered one edge early so it is high exactly during the final ACCESS cycle
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_fault    <= 1'b0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_memWe    <= 1'b0;
      r_memA     <= 32'd0;
      r_memWd    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_we       <= bus.req_we_i;
            r_fault    <= w_fault;
            r_memA     <= w_addr;
            r_memWd    <= bus.req_wdata_i;
            r_cnt      <= 4'(WAIT_CYCLES);
            r_memWe    <= bus.req_we_i && !w_fault && (WAIT_CYCLES == 0);
            r_reqReady <= 1'b0;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_rdata    <= (!r_we && !r_fault) ? mem_rd_i : 32'd0;
            r_err      <= r_fault;
            r_memWe    <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
            r_memWe <= (r_cnt == 4'd1) && r_we && !r_fault;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_memWe    <= 1'b0;
          r_rspValid <= 1'b0;
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_reqReady;
  assign bus.rsp_valid_o = r_rspValid;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;
  assign mem_we_o        = r_memWe;
  assign mem_a_o         = r_memA;
  assign mem_wd_o        = r_memWd;

endmodule

// File: tb/tb_ucsbece154a_memif.sv
// Directed bench for ucsbece154a_memif: instance 0 has no wait states, instance 1 has three.
module tb_ucsbece154a_memif;

   logic clk;
   logic resetN;

   logic [1:0]       reqValid;
   logic [1:0]       reqWe;
   logic [1:0][31:0] reqAddr;
   logic [1:0][31:0] reqWdata;
   logic [1:0]       rspReady;

   logic [1:0]       reqReady;
   logic [1:0]       rspValid;
   logic [1:0][31:0] rspRdata;
   logic [1:0]       rspErr;
   logic [1:0]       memWe;
   logic [1:0][31:0] memA;
   logic [1:0][31:0] memWd;

   int testsRun;
   int testsFailed;
   int edges;

   for (genvar g = 0; g < 2; g++) begin : gInst
      localparam int WAIT = (g == 0) ? 0 : 3;
      ucsbece154a_memif_if bus();
      logic [31:0] memRd;
      logic [31:0] textMem [64];
      logic [31:0] dataMem [64];
      int weCount;

      assign bus.req_valid_i = reqValid[g];
      assign bus.req_we_i    = reqWe[g];
      assign bus.req_addr_i  = reqAddr[g];
      assign bus.req_wdata_i = reqWdata[g];
      assign bus.rsp_ready_i = rspReady[g];
      assign reqReady[g]     = bus.req_ready_o;
      assign rspValid[g]     = bus.rsp_valid_o;
      assign rspRdata[g]     = bus.rsp_rdata_o;
      assign rspErr[g]       = bus.rsp_err_o;

      ucsbece154a_memif #(.WAIT_CYCLES(WAIT)) dut (
         .clk       (clk),
         .reset_n_i (resetN),
         .bus       (bus.slave),
         .mem_we_o  (memWe[g]),
         .mem_a_o   (memA[g]),
         .mem_wd_o  (memWd[g]),
         .mem_rd_i  (memRd)
      );

      // Behavioural memory: combinational read, undriven outside the map, write on the rising edge
      assign memRd = (memA[g] >= 32'h0040_0000 && memA[g] < 32'h0040_0100) ? textMem[memA[g][7:2]] :
                     (memA[g] >= 32'h1000_0000 && memA[g] < 32'h1000_0100) ? dataMem[memA[g][7:2]] :
                     32'hzzzz_zzzz;

      initial begin
         weCount = 0;
         for (int i = 0; i < 64; i++) begin
            textMem[i] = 32'h0;
            dataMem[i] = 32'h0;
         end
         textMem[0]  = 32'h0050_0113;
         textMem[1]  = 32'h2002_000A;
         dataMem[0]  = 32'hCAFE_F00D;
         dataMem[63] = 32'h600D_F00D;
      end

      always @(posedge clk) begin
         if (memWe[g]) begin
            weCount <= weCount + 1;
            if (memA[g] >= 32'h0040_0000 && memA[g] < 32'h0040_0100)
               textMem[memA[g][7:2]] <= memWd[g];
            else if (memA[g] >= 32'h1000_0000 && memA[g] < 32'h1000_0100)
               dataMem[memA[g][7:2]] <= memWd[g];
         end
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int s, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, output int nEdges);
      @(negedge clk);
      reqValid[s] = 1'b1;
      reqWe[s]    = we;
      reqAddr[s]  = addr;
      reqWdata[s] = wdata;
      @(posedge clk);
      nEdges = 1;
      @(negedge clk);
      reqValid[s] = 1'b0;
      while (!rspValid[s] && nEdges < 20) begin
         @(posedge clk);
         nEdges++;
         @(negedge clk);
      end
   endtask

   task automatic releaseRsp(input int s);
      @(negedge clk);
      rspReady[s] = 1'b1;
      @(negedge clk);
      rspReady[s] = 1'b0;
      checkOutput("relValid", {31'd0, rspValid[s]}, 32'd0);
      checkOutput("relReady", {31'd0, reqReady[s]}, 32'd1);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      resetN      = 1'b0;
      reqValid    = '0;
      reqWe       = '0;
      reqAddr     = '0;
      reqWdata    = '0;
      rspReady    = '0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;

      for (int s = 0; s < 2; s++) begin
         checkOutput("rstReady", {31'd0, reqReady[s]}, 32'd1);
         checkOutput("rstValid", {31'd0, rspValid[s]}, 32'd0);
         checkOutput("rstRdata", rspRdata[s], 32'd0);
         checkOutput("rstErr",   {31'd0, rspErr[s]}, 32'd0);
         checkOutput("rstMemWe", {31'd0, memWe[s]}, 32'd0);
         checkOutput("rstMemA",  memA[s], 32'd0);
         checkOutput("rstMemWd", memWd[s], 32'd0);
      end

      applyStimulus(0, 1'b0, 32'h0040_0004, 32'h0, edges);
      checkOutput("ldTextEdges", edges, 32'd2);
      checkOutput("ldTextData",  rspRdata[0], 32'h2002_000A);
      checkOutput("ldTextErr",   {31'd0, rspErr[0]}, 32'd0);
      checkOutput("ldTextWe",    gInst[0].weCount, 32'd0);
      releaseRsp(0);

      applyStimulus(0, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, edges);
      checkOutput("stEdges", edges, 32'd2);
      checkOutput("stErr",   {31'd0, rspErr[0]}, 32'd0);
      checkOutput("stRdata", rspRdata[0], 32'd0);
      checkOutput("stWeCnt", gInst[0].weCount, 32'd1);
      checkOutput("stMem",   gInst[0].dataMem[2], 32'hDEAD_BEEF);
      releaseRsp(0);
      applyStimulus(0, 1'b0, 32'h1000_0008, 32'h0, edges);
      checkOutput("ldBackData", rspRdata[0], 32'hDEAD_BEEF);
      checkOutput("ldBackErr",  {31'd0, rspErr[0]}, 32'd0);
      releaseRsp(0);

      applyStimulus(0, 1'b1, 32'h0040_0000, 32'h1111_2222, edges);
      checkOutput("stTextErr",   {31'd0, rspErr[0]}, 32'd1);
      checkOutput("stTextRdata", rspRdata[0], 32'd0);
      checkOutput("stTextWeCnt", gInst[0].weCount, 32'd1);
      checkOutput("stTextMem",   gInst[0].textMem[0], 32'h0050_0113);
      releaseRsp(0);
      applyStimulus(0, 1'b0, 32'h0000_0000, 32'h0, edges);
      checkOutput("ldZeroErr",   {31'd0, rspErr[0]}, 32'd1);
      checkOutput("ldZeroRdata", rspRdata[0], 32'd0);
      checkOutput("ldZeroWeCnt", gInst[0].weCount, 32'd1);
      releaseRsp(0);

      applyStimulus(1, 1'b0, 32'h1000_00FC, 32'h0, edges);
      checkOutput("lastEdges", edges, 32'd5);
      checkOutput("lastData",  rspRdata[1], 32'h600D_F00D);
      checkOutput("lastErr",   {31'd0, rspErr[1]}, 32'd0);
      releaseRsp(1);
      applyStimulus(1, 1'b0, 32'h1000_0100, 32'h0, edges);
      checkOutput("pastEdges", edges, 32'd5);
      checkOutput("pastErr",   {31'd0, rspErr[1]}, 32'd1);
      checkOutput("pastRdata", rspRdata[1], 32'd0);
      releaseRsp(1);

      applyStimulus(0, 1'b0, 32'h0040_0004, 32'h0, edges);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            reqValid[0] = 1'b1;
            reqWe[0]    = 1'b1;
            reqAddr[0]  = 32'h1000_0008;
            reqWdata[0] = 32'h1111_1111;
         end
         if (i == 2) reqValid[0] = 1'b0;
         @(negedge clk);
         checkOutput("holdValid", {31'd0, rspValid[0]}, 32'd1);
         checkOutput("holdReady", {31'd0, reqReady[0]}, 32'd0);
         checkOutput("holdRdata", rspRdata[0], 32'h2002_000A);
      end
      releaseRsp(0);
      repeat (2) @(negedge clk);
      checkOutput("ignValid", {31'd0, rspValid[0]}, 32'd0);
      checkOutput("ignAddr",  memA[0], 32'h0040_0004);
      checkOutput("ignWeCnt", gInst[0].weCount, 32'd1);
      checkOutput("ignMem",   gInst[0].dataMem[2], 32'hDEAD_BEEF);

      applyStimulus(0, 1'b0, 32'h1000_0002, 32'h0, edges);
`ifdef UCSBECE154A_MEMIF_ALIGN_CHECK_EN
      checkOutput("misErr",   {31'd0, rspErr[0]}, 32'd1);
      checkOutput("misRdata", rspRdata[0], 32'd0);
`else
      checkOutput("misErr",   {31'd0, rspErr[0]}, 32'd0);
      checkOutput("misAddr",  memA[0], 32'h1000_0000);
      checkOutput("misRdata", rspRdata[0], 32'hCAFE_F00D);
`endif
      releaseRsp(0);

      @(negedge clk);
      reqValid[1] = 1'b1;
      reqWe[1]    = 1'b1;
      reqAddr[1]  = 32'h1000_0000;
      reqWdata[1] = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      reqValid[1] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("preRstWe", {31'd0, memWe[1]}, 32'd1);
      checkOutput("preRstWd", memWd[1], 32'h1234_5678);
      resetN = 1'b0;
      #1;
      checkOutput("abortWe",    {31'd0, memWe[1]}, 32'd0);
      checkOutput("abortA",     memA[1], 32'd0);
      checkOutput("abortWd",    memWd[1], 32'd0);
      checkOutput("abortReady", {31'd0, reqReady[1]}, 32'd1);
      checkOutput("abortValid", {31'd0, rspValid[1]}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abortMem",   gInst[1].dataMem[0], 32'hCAFE_F00D);
      checkOutput("abortWeCnt", gInst[1].weCount, 32'd0);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
